// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the instruction fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush, exposing head entry and occupancy
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    assign head = mem[rd_ptr];

    // Storage and pointers; flush empties the queue, pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, credit-limited imem requests, response buffering and redirect flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                N_Bits     = 32,
    parameter logic [N_Bits-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [N_Bits-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [N_Bits-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [N_Bits-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_Bits-1:0] out_instr,
    output logic [N_Bits-1:0] out_pc,
    output logic [N_Bits-1:0] out_pc_plus4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state, state_next;
    logic [N_Bits-1:0] pc, pc_next, rsp_pc;
    logic [CW-1:0]     outstanding, outstanding_next;
    logic [CW-1:0]     discard, discard_next;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_use;
    logic [2*N_Bits-1:0] head;
    logic              redirect, req_hs, rsp_keep, pop;

    assign redirect       = redirect_valid && state != IDLE;
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = state == RUN && !redirect_valid && in_use < (CW+1)'(FIFO_DEPTH);
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && state == RUN && !redirect_valid;
    // In RUN every outstanding request was issued sequentially from the current stream,
    // so the oldest one (the one now responding) sits outstanding words behind pc.
    assign rsp_pc         = pc - N_Bits'(outstanding) * N_Bits'(PC_STEP);
    assign out_valid      = fifo_count != '0;
    assign pop            = out_valid && out_ready;
    assign {out_pc, out_instr} = head;
    assign out_pc_plus4   = out_pc + N_Bits'(PC_STEP);

    fetch_fifo #(
        .WIDTH (2 * N_Bits),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (fifo_count)
    );

    // Next state: a redirect turns all outstanding requests into responses to discard
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        outstanding_next = outstanding;
        discard_next     = discard;
        if (redirect) begin
            pc_next          = redirect_pc & ~N_Bits'(3);
            outstanding_next = '0;
            discard_next     = discard + outstanding - CW'(imem_rsp_valid);
            state_next       = (discard_next != '0) ? FLUSH : RUN;
        end else begin
            pc_next          = req_hs ? pc + N_Bits'(PC_STEP) : pc;
            outstanding_next = outstanding + CW'(req_hs) - CW'(rsp_keep);
            discard_next     = discard - CW'(imem_rsp_valid && state == FLUSH);
            state_next       = (state == IDLE) ? RUN :
                               (state == FLUSH && discard_next == '0) ? RUN : state;
        end
    end

    // State, PC and credit/discard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
        end
    end

    // A response with nothing outstanding or pending discard breaks the memory protocol
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(imem_rsp_valid && outstanding == '0 && discard == '0));
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a transaction-level fetch model
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pc_plus4;

    fetch_unit #(.N_Bits(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];

    int errors = 0, checks = 0, cyc = 0;
    int lat_min = 1, lat_max = 1;
    int stale_cnt = 0, expect_req_cyc = -1, last_due = 0;
    int req_cnt = 0, pop_cnt = 0, first_req_cyc = -1, first_pop_cyc = -1;
    logic [31:0] exp_req = 0, exp_out = 0;
    logic [31:0] held_pc, held_instr, held_addr;
    bit prev_redirect = 0, hold_out = 0, hold_req = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, check DUT against model, advance model, step clock
    task automatic tick();
        bit    stale_now;
        int    d;
        mreq_t m;
        stale_now = 0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
            if (stale_cnt > 0) begin
                stale_cnt--;
                stale_now = 1;
                if (stale_cnt == 0) expect_req_cyc = cyc + 1;
            end
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #1;
        if (prev_redirect) chk("out_valid_after_redirect", 32'(out_valid), 0);
        if (hold_out && !prev_redirect) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_pc", out_pc, held_pc);
            chk("hold_instr", out_instr, held_instr);
        end
        if (hold_req && !prev_redirect && req_valid) chk("hold_addr", req_addr, held_addr);
        if (redirect_valid || stale_cnt > 0 || stale_now) chk("no_req_in_flush", 32'(req_valid), 0);
        else if (cyc == expect_req_cyc) chk("resume_req", 32'(req_valid), 1);
        chk("credit_bound", 32'(mq.size() <= DEPTH), 1);
        if (req_valid && req_ready) begin
            chk("req_addr", req_addr, exp_req);
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            m.addr = req_addr;
            m.due  = d;
            mq.push_back(m);
            exp_req += 32'd4;
            req_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            chk("out_pc", out_pc, exp_out);
            chk("out_instr", out_instr, mem_word(exp_out));
            chk("out_pc_plus4", out_pc_plus4, exp_out + 32'd4);
            exp_out += 32'd4;
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        hold_out   = out_valid && !out_ready;
        held_pc    = out_pc;
        held_instr = out_instr;
        hold_req   = req_valid && !req_ready;
        held_addr  = req_addr;
        prev_redirect = redirect_valid;
        if (redirect_valid) begin
            exp_req        = redirect_pc & ~32'd3;
            exp_out        = exp_req;
            stale_cnt      = mq.size();
            expect_req_cyc = (mq.size() == 0) ? cyc + 1 : -1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset (async), check reset values, release, and check IDLE then first request
    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        rsp_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_pc_plus4", out_pc_plus4, 32'h4);
        mq.delete();
        stale_cnt = 0; expect_req_cyc = -1; last_due = cyc;
        hold_out = 0; hold_req = 0; prev_redirect = 0;
        exp_req = 0; exp_out = 0;
        req_cnt = 0; pop_cnt = 0; first_req_cyc = -1; first_pop_cyc = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_no_req", 32'(req_valid), 0);
        tick();
        #1;
        chk("first_req_valid", 32'(req_valid), 1);
        chk("first_req_addr", req_addr, 32'h0);
    endtask

    initial begin
        int p;
        bit found;
        req_ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        rsp_valid = 1'b0; rsp_data = '0;
        @(negedge clk);

        // streaming, latency 1
        do_reset();
        repeat (20) tick();
        chk("first_out_latency", 32'(first_pop_cyc - first_req_cyc), 2);
        chk("stream_progress", 32'(pop_cnt >= 5), 1);

        // consumer stalled from reset: credit limits requests to two
        out_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("stall_req_count", 32'(req_cnt), 2);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_out_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        repeat (10) tick();
        chk("stall_release_progress", 32'(pop_cnt >= 3), 1);

        // latency 3, redirect with two in flight
        lat_min = 3; lat_max = 3;
        repeat (12) tick();
        for (int i = 0; i < 20 && mq.size() != 2; i++) tick();
        chk("two_outstanding", 32'(mq.size()), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        p = pop_cnt;
        repeat (15) tick();
        chk("post_flush_progress", 32'(pop_cnt > p), 1);

        // redirect to unaligned target with nothing outstanding
        out_ready = 1'b0;
        repeat (10) tick();
        chk("quiet_before_redirect", 32'(mq.size()), 0);
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("aligned_req_valid", 32'(req_valid), 1);
        chk("aligned_req_addr", req_addr, 32'h200);
        out_ready = 1'b1;
        p = pop_cnt;
        repeat (8) tick();
        chk("aligned_progress", 32'(pop_cnt > p), 1);

        // redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (out_valid && mq.size() > 0 && mq[0].due <= cyc) found = 1;
            else tick();
        end
        chk("coincident_found", 32'(found), 1);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        p = pop_cnt;
        tick();
        redirect_valid = 1'b0;
        chk("coincident_pop", 32'(pop_cnt), 32'(p + 1));
        repeat (10) tick();

        // random traffic: latency 1..4, random readiness and redirects
        lat_min = 1; lat_max = 4;
        p = pop_cnt;
        for (int i = 0; i < 3000; i++) begin
            req_ready      = $urandom_range(3, 0) != 0;
            out_ready      = $urandom_range(3, 0) != 0;
            redirect_valid = $urandom_range(40, 0) == 0;
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0; req_ready = 1'b1; out_ready = 1'b1;
        chk("random_progress", 32'(pop_cnt - p > 100), 1);

        // reset mid-stream with a full buffer
        lat_min = 1; lat_max = 1;
        out_ready = 1'b0;
        repeat (12) tick();
        chk("full_out_valid", 32'(out_valid), 1);
        chk("full_no_inflight", 32'(mq.size()), 0);
        do_reset();
        out_ready = 1'b1;
        repeat (10) tick();
        chk("after_reset_progress", 32'(pop_cnt >= 3), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
